alu_operand_sequencer: RTL and testbench

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_seq_pkg.sv | 11 +
 rtl/alu_operand_sequencer.sv | 72 +++++++
 tb/tb_alu_operand_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared defaults and state encoding for the ALU operand sequencer
package alu_seq_pkg;
  localparam int WIDTH_DEF = 5;
  localparam int SEL_W_DEF = 2;
  localparam int CNT_W_DEF = 8;
  typedef logic [1:0] state_t;
  localparam state_t GET_A = 2'd0;
  localparam state_t GET_B = 2'd1;
  localparam state_t EXEC  = 2'd2;
  localparam state_t HOLD  = 2'd3;
endpackage

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects A/B operands, drives an external ALU and hands the result downstream
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_select,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic [CNT_W-1:0] op_count
);
  state_t state;
  logic [WIDTH-1:0] last_result;
  assign in_ready  = (state == GET_A) || (state == GET_B);
  assign out_valid = (state == HOLD);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= GET_A;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_select  <= '0;
      out_data    <= '0;
      out_sel     <= '0;
      last_result <= '0;
      op_count    <= '0;
    end else begin
      case (state)
        GET_A: if (in_valid) begin
          // chained op: the new word is B and the previous result becomes A
          if (in_chain) begin
            alu_a      <= last_result;
            alu_b      <= in_data;
            alu_select <= in_sel;
            state      <= EXEC;
          end else begin
            alu_a <= in_data;
            state <= GET_B;
          end
        end
        GET_B: if (in_valid) begin
          alu_b      <= in_data;
          alu_select <= in_sel;
          state      <= EXEC;
        end
        EXEC: begin
          out_data    <= alu_result;
          out_sel     <= alu_select;
          last_result <= alu_result;
          state       <= HOLD;
        end
        default: if (out_ready) begin
          op_count <= op_count + 1'b1;
          state    <= GET_A;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed and table-driven checks with an adder standing in for the ALU
module tb_alu_operand_sequencer;
  logic clk = 0, reset, in_valid, in_ready, in_chain, out_valid, out_ready;
  logic [4:0] in_data, alu_a, alu_b, alu_result, out_data;
  logic [1:0] in_sel, alu_select, out_sel;
  logic [7:0] op_count;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;
  assign alu_result = alu_a + alu_b;

  alu_operand_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_chain(in_chain), .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .op_count(op_count)
  );

  typedef struct {
    logic       chain;
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] sel;
    logic [4:0] exp_a;
    logic [4:0] exp_out;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [4:0] d, logic [1:0] s, logic c);
    int n = 0;
    in_data = d; in_sel = s; in_chain = c; in_valid = 1;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("out_valid_wait", {31'd0, out_valid}, 1);
  endtask

  task automatic take();
    wait_valid();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic check_cleared(string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_alu_a"}, {27'd0, alu_a}, 0);
    chk({tag, "_alu_b"}, {27'd0, alu_b}, 0);
    chk({tag, "_alu_select"}, {30'd0, alu_select}, 0);
    chk({tag, "_out_data"}, {27'd0, out_data}, 0);
    chk({tag, "_out_sel"}, {30'd0, out_sel}, 0);
    chk({tag, "_op_count"}, {24'd0, op_count}, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    vecs[0] = '{0, 5'd3,  5'd4,  2'd2, 5'd3,  5'd7};
    vecs[1] = '{1, 5'd0,  5'd9,  2'd3, 5'd7,  5'd16};
    vecs[2] = '{0, 5'd31, 5'd31, 2'd1, 5'd31, 5'd30};
    vecs[3] = '{1, 5'd0,  5'd2,  2'd0, 5'd30, 5'd0};
    vecs[4] = '{0, 5'd0,  5'd0,  2'd3, 5'd0,  5'd0};
    in_valid = 0; in_data = 0; in_sel = 0; in_chain = 0; out_ready = 0;
    reset = 1;
    tick();
    check_cleared("reset");
    tick();
    reset = 0;

    put(5'b00101, 2'b10, 1);
    chk("chain_rst_alu_a", {27'd0, alu_a}, 0);
    wait_valid();
    chk("chain_rst_out_data", {27'd0, out_data}, 5'b00101);
    take();

    do_reset();
    put(5'b01010, 2'b00, 0);
    put(5'b10101, 2'b00, 0);
    chk("basic_lat_edge1", {31'd0, out_valid}, 0);
    tick();
    chk("basic_lat_edge2", {31'd0, out_valid}, 1);
    chk("basic_out_data", {27'd0, out_data}, 5'b11111);
    chk("basic_out_sel", {30'd0, out_sel}, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("basic_op_count", {24'd0, op_count}, 1);
    chk("basic_back_get_a", {31'd0, in_ready}, 1);

    put(5'b00001, 2'b01, 1);
    chk("chain_alu_a", {27'd0, alu_a}, 5'b11111);
    chk("chain_alu_select", {30'd0, alu_select}, 2'b01);
    wait_valid();
    chk("chain_out_data", {27'd0, out_data}, 0);
    chk("chain_out_sel", {30'd0, out_sel}, 2'b01);

    in_valid = 1; in_data = 5'd7; in_chain = 0; in_sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_data", {27'd0, out_data}, 0);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_out_valid", {31'd0, out_valid}, 1);
      chk("bp_alu_b", {27'd0, alu_b}, 5'b00001);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    chk("bp_op_count", {24'd0, op_count}, 2);
    tick();
    out_ready = 0;
    chk("bp_single_xfer", {24'd0, op_count}, 2);
    chk("bp_out_valid_low", {31'd0, out_valid}, 0);

    for (int i = 0; i < 5; i++) begin
      if (!vecs[i].chain) put(vecs[i].a, 2'd0, 0);
      put(vecs[i].b, vecs[i].sel, vecs[i].chain);
      wait_valid();
      chk($sformatf("vec%0d_alu_a", i), {27'd0, alu_a}, vecs[i].exp_a);
      chk($sformatf("vec%0d_out_data", i), {27'd0, out_data}, vecs[i].exp_out);
      chk($sformatf("vec%0d_out_sel", i), {30'd0, out_sel}, vecs[i].sel);
      take();
      chk($sformatf("vec%0d_op_count", i), {24'd0, op_count}, 3 + i);
    end

    put(5'd3, 2'd1, 0);
    put(5'd4, 2'd2, 0);
    reset = 1;
    #1;
    check_cleared("rst_exec");
    #2 reset = 0;
    put(5'd9, 2'd1, 1);
    wait_valid();
    reset = 1;
    #1;
    check_cleared("rst_hold");
    #2 reset = 0;

    for (int i = 0; i < 256; i++) begin
      put(5'd1, 2'd0, 1);
      take();
      if (i == 254) chk("wrap_255", {24'd0, op_count}, 255);
    end
    chk("wrap_0", {24'd0, op_count}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
